// File: rtl/lustre_signed_window_minmax_pkg.sv
// Shared definitions for the windowed signed min/max block: FSM encoding and
// the width helper for the in-window sample counter.
package lustre_signed_window_minmax_pkg;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // Counter must represent 0..W so the closing sample's count can be compared to W.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/lustre_signed_window_minmax_step.sv
// Combinational min/max update for one sample, with signed less-than derived
// from the N and V flags of lhs + ~rhs + 1.
module internal_lustre_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         flag_n_o,
  output logic         flag_v_o
);
  assign sum_o    = a_i + b_i + N'(cin_i);
  assign flag_n_o = sum_o[N-1];
  assign flag_v_o = (a_i[N-1] == b_i[N-1]) && (sum_o[N-1] != a_i[N-1]);
endmodule

module internal_lustre_minmax_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] sample_i,
  input  logic [N-1:0] cur_min_i,
  input  logic [N-1:0] cur_max_i,
  input  logic         first_i,
  output logic [N-1:0] nxt_min_o,
  output logic [N-1:0] nxt_max_o
);
  logic [N-1:0] sum_lo, sum_hi;
  logic         n_lo, v_lo, n_hi, v_hi;
  logic         smp_lt_min, max_lt_smp;

  // sample < cur_min
  internal_lustre_adder #(.N(N)) u_lt_min (
    .a_i(sample_i), .b_i(~cur_min_i), .cin_i(1'b1),
    .sum_o(sum_lo), .flag_n_o(n_lo), .flag_v_o(v_lo)
  );

  // cur_max < sample
  internal_lustre_adder #(.N(N)) u_lt_max (
    .a_i(cur_max_i), .b_i(~sample_i), .cin_i(1'b1),
    .sum_o(sum_hi), .flag_n_o(n_hi), .flag_v_o(v_hi)
  );

  assign smp_lt_min = n_lo ^ v_lo;
  assign max_lt_smp = n_hi ^ v_hi;

  // Strict compares: ties keep the held extreme.
  assign nxt_min_o = (first_i || smp_lt_min) ? sample_i : cur_min_i;
  assign nxt_max_o = (first_i || max_lt_smp) ? sample_i : cur_max_i;
endmodule

// File: rtl/lustre_signed_window_minmax.sv
// Running signed min/max over windows of W accepted samples; publishes the
// extremes of each completed window with a one-cycle pulse.
module lustre_signed_window_minmax
  import lustre_signed_window_minmax_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int W  = 4,
  localparam int CW = cnt_width(W)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  input  logic          clear,
  output logic          any,
  output logic [CW-1:0] count,
  output logic [N-1:0]  run_min,
  output logic [N-1:0]  run_max,
  output logic          win_valid,
  output logic [N-1:0]  win_min,
  output logic [N-1:0]  win_max
);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  rmin_q, rmin_d, rmax_q, rmax_d;
  logic [N-1:0]  wmin_q, wmin_d, wmax_q, wmax_d;
  logic          wv_q, wv_d;

  logic          first;
  logic [CW-1:0] cnt_base, cnt_new;
  logic          close;
  logic [N-1:0]  nxt_min, nxt_max;

  // A clear alongside a sample restarts the window with that sample.
  assign first    = (state_q == ST_EMPTY) || clear;
  assign cnt_base = first ? '0 : cnt_q;
  assign cnt_new  = cnt_base + CW'(1);
  assign close    = in_valid && (cnt_new == CW'(W));

  internal_lustre_minmax_step #(.N(N)) u_step (
    .sample_i (in_data),
    .cur_min_i(rmin_q),
    .cur_max_i(rmax_q),
    .first_i  (first),
    .nxt_min_o(nxt_min),
    .nxt_max_o(nxt_max)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rmin_d  = rmin_q;
    rmax_d  = rmax_q;
    wmin_d  = wmin_q;
    wmax_d  = wmax_q;
    wv_d    = 1'b0;
    if (in_valid) begin
      rmin_d = nxt_min;
      rmax_d = nxt_max;
      if (close) begin
        state_d = ST_EMPTY;
        cnt_d   = '0;
        wmin_d  = nxt_min;
        wmax_d  = nxt_max;
        wv_d    = 1'b1;
      end else begin
        state_d = ST_RUN;
        cnt_d   = cnt_new;
      end
    end else if (clear) begin
      state_d = ST_EMPTY;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      rmin_q  <= '0;
      rmax_q  <= '0;
      wmin_q  <= '0;
      wmax_q  <= '0;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rmin_q  <= rmin_d;
      rmax_q  <= rmax_d;
      wmin_q  <= wmin_d;
      wmax_q  <= wmax_d;
      wv_q    <= wv_d;
    end
  end

  assign any       = (state_q == ST_RUN);
  assign count     = cnt_q;
  assign run_min   = rmin_q;
  assign run_max   = rmax_q;
  assign win_valid = wv_q;
  assign win_min   = wmin_q;
  assign win_max   = wmax_q;

endmodule
